// File: rtl/mfp_reset_sequencer.sv
// -----------------------------------------------------------------------------
// mfp_reset_sequencer
//
// Board-level reset sequencer for the MIPSfpga-plus tops. Collects the raw
// reset sources (external active-low requests, PLL lock, software pulse),
// synchronises and debounces them, holds every domain in reset for a minimum
// width after the last request, then releases the domains one at a time,
// lowest index first. The cause of the most recent run-time reset is kept in
// a sticky register.
//
// Ports:
//   clk           system clock
//   resetn        asynchronous active-low power-on reset of this block
//   src_req_n     [N_SRC]      asynchronous active-low reset requests
//   src_mask      [N_SRC]      1 = request source enabled (quasi-static)
//   pll_locked    asynchronous PLL lock, low = reset request
//   sw_reset_req  synchronous one-cycle software reset pulse
//   cause_clr     synchronous clear of last_cause
//   rst_n_out     [N_DOMAINS]  registered active-low domain resets
//   reset_active  registered, high while any rst_n_out bit is low
//   last_cause    [N_SRC+2]    sticky cause: {sw, pll loss, sources}
//   state_dbg     [2]          current sequencer state (0 ASSERT,
//                              1 RELEASE, 2 RUN)
// -----------------------------------------------------------------------------
module mfp_reset_sequencer #(
   parameter int N_SRC           = 2,
   parameter int N_DOMAINS       = 3,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MIN_ASSERT      = 16,
   parameter int STAGE_DELAY     = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [N_SRC-1:0]     src_req_n,
   input  logic [N_SRC-1:0]     src_mask,
   input  logic                 pll_locked,
   input  logic                 sw_reset_req,
   input  logic                 cause_clr,
   output logic [N_DOMAINS-1:0] rst_n_out,
   output logic                 reset_active,
   output logic [N_SRC+1:0]     last_cause,
   output logic [1:0]           state_dbg
);

   localparam int MAX_AS = (MIN_ASSERT > STAGE_DELAY) ? MIN_ASSERT : STAGE_DELAY;
   localparam int MAX_C  = (MAX_AS > DEBOUNCE_CYCLES) ? MAX_AS : DEBOUNCE_CYCLES;
   localparam int CW     = $clog2(MAX_C) + 1;

   localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] ASSERT_LAST = CW'(MIN_ASSERT - 1);
   localparam logic [CW-1:0] STAGE_LAST  = CW'(STAGE_DELAY - 1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronisers. Request flops idle at 1 (no request); the PLL chain
   // idles at 0 so a fresh power-on always counts as one request cycle.
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] src_sync [N_SRC];
   logic [SYNC_STAGES-1:0] pll_sync;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < N_SRC; i++) src_sync[i] <= '1;
         pll_sync <= '0;
      end else begin
         for (int i = 0; i < N_SRC; i++)
            src_sync[i] <= {src_sync[i][SYNC_STAGES-2:0], src_req_n[i]};
         pll_sync <= {pll_sync[SYNC_STAGES-2:0], pll_locked};
      end
   end

   // ---------------------------------------------------------------------------
   // Per-source debounce: the debounced level only follows the synchronised
   // level after DEBOUNCE_CYCLES consecutive samples that disagree with it.
   // ---------------------------------------------------------------------------
   logic [N_SRC-1:0] deb_req_n;
   logic [CW-1:0]    deb_cnt [N_SRC];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         deb_req_n <= '1;
         for (int i = 0; i < N_SRC; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (src_sync[i][SYNC_STAGES-1] == deb_req_n[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb_req_n[i] <= src_sync[i][SYNC_STAGES-1];
               deb_cnt[i]   <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Request terms laid out exactly like last_cause so capture is a plain OR.
   logic [N_SRC+1:0] req_terms;
   logic             req_any;

   assign req_terms = {sw_reset_req, ~pll_sync[SYNC_STAGES-1], ~deb_req_n & src_mask};
   assign req_any   = |req_terms;

   // ---------------------------------------------------------------------------
   // Sequencer state register
   // ---------------------------------------------------------------------------
   state_t                 state, state_next;
   logic [CW-1:0]          cnt, cnt_next;
   logic [N_DOMAINS-1:0]   rst_next;
   logic [N_DOMAINS-1:0]   stage_fill;
   logic                   active_next;
   logic [N_SRC+1:0]       cause_next;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_ASSERT;
         cnt          <= '0;
         rst_n_out    <= '0;
         reset_active <= 1'b1;
         last_cause   <= '0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         rst_n_out    <= rst_next;
         reset_active <= active_next;
         last_cause   <= cause_next;
      end
   end

   assign state_dbg = state;

   // rst_n_out is a thermometer code: releasing the next stage means shifting
   // one more 1 in from the bottom.
   always_comb begin
      stage_fill    = '0;
      stage_fill[0] = 1'b1;
      for (int i = 1; i < N_DOMAINS; i++) stage_fill[i] = rst_n_out[i-1];
   end

   // ---------------------------------------------------------------------------
   // Next-state, output and cause logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      rst_next   = rst_n_out;
      cause_next = cause_clr ? '0 : last_cause;

      unique case (state)
         ST_ASSERT: begin
            // Requests seen while already in reset only restart the width
            // timer; they are deliberately not recorded as causes.
            rst_next = '0;
            if (req_any) begin
               cnt_next = '0;
            end else if (cnt == ASSERT_LAST) begin
               cnt_next    = '0;
               rst_next[0] = 1'b1;
               state_next  = (N_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end

         ST_RELEASE: begin
            if (req_any) begin
               state_next = ST_ASSERT;
               rst_next   = '0;
               cnt_next   = '0;
               cause_next = cause_next | req_terms;
            end else if (cnt == STAGE_LAST) begin
               cnt_next = '0;
               rst_next = stage_fill;
               if (&stage_fill) state_next = ST_RUN;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end

         ST_RUN: begin
            rst_next = '1;
            cnt_next = '0;
            if (req_any) begin
               state_next = ST_ASSERT;
               rst_next   = '0;
               cause_next = cause_next | req_terms;
            end
         end

         default: begin
            state_next = ST_ASSERT;
            rst_next   = '0;
            cnt_next   = '0;
         end
      endcase

      active_next = ~&rst_next;
   end

endmodule

// File: tb/tb_mfp_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mfp_reset_sequencer
//
// Drives mfp_reset_sequencer (default parameters) from a table of
// {inputs, cycles to run, expected outputs} records. Each record pushes its
// expected observation {reset_active, rst_n_out, last_cause} into exp_q when
// its inputs are driven; the observation is popped and compared once the
// record's cycles have elapsed. Power-on and the asynchronous mid-sequence
// reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mfp_reset_sequencer;

   localparam int W = 8;

   logic       clk;
   logic       resetn;
   logic [1:0] src_req_n;
   logic [1:0] src_mask;
   logic       pll_locked;
   logic       sw_reset_req;
   logic       cause_clr;
   logic [2:0] rst_n_out;
   logic       reset_active;
   logic [3:0] last_cause;
   logic [1:0] state_dbg;

   mfp_reset_sequencer #(
      .N_SRC(2), .N_DOMAINS(3), .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(4), .MIN_ASSERT(16), .STAGE_DELAY(8)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .src_req_n    (src_req_n),
      .src_mask     (src_mask),
      .pll_locked   (pll_locked),
      .sw_reset_req (sw_reset_req),
      .cause_clr    (cause_clr),
      .rst_n_out    (rst_n_out),
      .reset_active (reset_active),
      .last_cause   (last_cause),
      .state_dbg    (state_dbg)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [W-1:0] exp_q[$];
   int           n_checks = 0;
   int           n_pass   = 0;

   typedef struct {
      int         n;
      logic [1:0] src_n;
      logic [1:0] mask;
      logic       pll;
      logic       sw;
      logic       clr;
      logic [2:0] rst;
      logic       act;
      logic [3:0] cause;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [W-1:0] observe();
      return {reset_active, rst_n_out, last_cause};
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got act/rst/cause=%b required %b", name, got, want);
   endtask

   task automatic check_state(input string name, input logic [1:0] want);
      n_checks++;
      if (state_dbg === want) n_pass++;
      else $display("FAIL %s: got state %0d required %0d", name, state_dbg, want);
   endtask

   task automatic sb_compare(input string name);
      logic [W-1:0] want;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         want = exp_q.pop_front();
         check(name, observe(), want);
      end
   endtask

   task automatic add(input int n, input logic [1:0] src_n, input logic [1:0] mask,
                      input logic pll, input logic sw, input logic clr,
                      input logic [2:0] rst, input logic act, input logic [3:0] cause);
      vec_t v;
      v.n = n; v.src_n = src_n; v.mask = mask; v.pll = pll; v.sw = sw; v.clr = clr;
      v.rst = rst; v.act = act; v.cause = cause;
      vecs.push_back(v);
   endtask

   // Inputs change right after a falling edge; outputs are sampled on the
   // falling edge n cycles later, so n rising edges have passed.
   task automatic run_vec(input int idx);
      vec_t v;
      v = vecs[idx];
      src_req_n    = v.src_n;
      src_mask     = v.mask;
      pll_locked   = v.pll;
      sw_reset_req = v.sw;
      cause_clr    = v.clr;
      exp_q.push_back({v.act, v.rst, v.cause});
      repeat (v.n) @(negedge clk);
      sb_compare($sformatf("vec%0d", idx));
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) run_vec(i);
   endtask

   task automatic add_powerup(input logic [3:0] cause);
      add(17, 2'b11, 2'b11, 1, 0, 0, 3'b000, 1, cause);
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, cause);
      add(7,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, cause);
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b011, 1, cause);
      add(7,  2'b11, 2'b11, 1, 0, 0, 3'b011, 1, cause);
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b111, 0, cause);
   endtask

   initial begin
      int powerup2_lo;

      // ---- stimulus table ----
      // power-up: releases at edges 18/26/34 after resetn rises
      add_powerup(4'b0000);                                   // 0..5
      // debounce: 3-cycle glitch ignored, 10-cycle request taken
      add(3,  2'b10, 2'b11, 1, 0, 0, 3'b111, 0, 4'b0000);     // 6
      add(10, 2'b11, 2'b11, 1, 0, 0, 3'b111, 0, 4'b0000);     // 7
      add(6,  2'b10, 2'b11, 1, 0, 0, 3'b111, 0, 4'b0000);     // 8
      add(1,  2'b10, 2'b11, 1, 0, 0, 3'b000, 1, 4'b0001);     // 9  edge 7
      add(3,  2'b10, 2'b11, 1, 0, 0, 3'b000, 1, 4'b0001);     // 10
      // request seen until edge 16, so releases at 32/40/48
      add(21, 2'b11, 2'b11, 1, 0, 0, 3'b000, 1, 4'b0001);     // 11
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, 4'b0001);     // 12
      add(7,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, 4'b0001);     // 13
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b011, 1, 4'b0001);     // 14
      add(7,  2'b11, 2'b11, 1, 0, 0, 3'b011, 1, 4'b0001);     // 15
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b111, 0, 4'b0001);     // 16
      // masked source held low
      add(50, 2'b01, 2'b01, 1, 0, 0, 3'b111, 0, 4'b0001);     // 17
      add(10, 2'b11, 2'b01, 1, 0, 0, 3'b111, 0, 4'b0001);     // 18
      // software reset
      add(1,  2'b11, 2'b11, 1, 1, 0, 3'b000, 1, 4'b1001);     // 19
      add(15, 2'b11, 2'b11, 1, 0, 0, 3'b000, 1, 4'b1001);     // 20
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, 4'b1001);     // 21
      // interrupted release: sw pulse 3 cycles after stage 0 rises
      add(2,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, 4'b1001);     // 22
      add(1,  2'b11, 2'b11, 1, 1, 0, 3'b000, 1, 4'b1001);     // 23
      add(15, 2'b11, 2'b11, 1, 0, 0, 3'b000, 1, 4'b1001);     // 24
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, 4'b1001);     // 25
      add(7,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, 4'b1001);     // 26
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b011, 1, 4'b1001);     // 27
      add(7,  2'b11, 2'b11, 1, 0, 0, 3'b011, 1, 4'b1001);     // 28
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b111, 0, 4'b1001);     // 29
      // 1-cycle PLL drop, cause_clr on the capture edge: set wins
      add(1,  2'b11, 2'b11, 0, 0, 0, 3'b111, 0, 4'b1001);     // 30
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b111, 0, 4'b1001);     // 31
      add(1,  2'b11, 2'b11, 1, 0, 1, 3'b000, 1, 4'b0100);     // 32 edge 3
      add(15, 2'b11, 2'b11, 1, 0, 0, 3'b000, 1, 4'b0100);     // 33
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, 4'b0100);     // 34
      add(1,  2'b11, 2'b11, 1, 0, 1, 3'b001, 1, 4'b0000);     // 35 later clear
      add(6,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, 4'b0000);     // 36
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b011, 1, 4'b0000);     // 37
      add(7,  2'b11, 2'b11, 1, 0, 0, 3'b011, 1, 4'b0000);     // 38
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b111, 0, 4'b0000);     // 39
      // sw reset, then into RELEASE for the asynchronous reset
      add(1,  2'b11, 2'b11, 1, 1, 0, 3'b000, 1, 4'b1000);     // 40
      add(15, 2'b11, 2'b11, 1, 0, 0, 3'b000, 1, 4'b1000);     // 41
      add(1,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, 4'b1000);     // 42
      add(3,  2'b11, 2'b11, 1, 0, 0, 3'b001, 1, 4'b1000);     // 43
      powerup2_lo = vecs.size();
      add_powerup(4'b0000);                                   // second power-up

      // ---- power-on reset ----
      resetn       = 1'b0;
      src_req_n    = 2'b11;
      src_mask     = 2'b11;
      pll_locked   = 1'b1;
      sw_reset_req = 1'b0;
      cause_clr    = 1'b0;
      repeat (3) @(negedge clk);
      exp_q.push_back({1'b1, 3'b000, 4'b0000});
      sb_compare("reset_values");
      check_state("reset_state", 2'd0);
      resetn = 1'b1;

      run_range(0, 5);
      check_state("run_state", 2'd2);
      run_range(6, powerup2_lo - 1);
      check_state("release_state", 2'd1);

      // ---- asynchronous reset mid-RELEASE: effect without a clock edge ----
      #1 resetn = 1'b0;
      exp_q.push_back({1'b1, 3'b000, 4'b0000});
      #1 sb_compare("async_reset");
      check_state("async_reset_state", 2'd0);
      @(negedge clk);
      resetn = 1'b1;
      run_range(powerup2_lo, powerup2_lo + 5);

      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mfp_reset_sequencer.md
# mfp_reset_sequencer

Parametrised board-level reset sequencer for the MIPSfpga-plus board tops. It sits between the raw reset sources and `mfp_system` and its peripherals. The raw sources are PLL lock, push-buttons, the EJTAG reset pin and a software request. The block synchronises and debounces each source, enforces a minimum reset width, and releases several reset domains in a fixed staged order: for example SDRAM controller first, then core, then video. It also keeps a sticky record of the cause of the last reset.

## Interface

Parameters:
- `N_SRC`, 2: number of external active-low reset request inputs.
- `N_DOMAINS`, 3: number of staged reset outputs.
- `SYNC_STAGES`, 2: synchroniser depth on every asynchronous input (≥2).
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to change a debounced source level (≥1; 1 = no filtering).
- `MIN_ASSERT`, 16: minimum cycles of all-domain reset after the last request (≥1).
- `STAGE_DELAY`, 8: cycles between consecutive domain releases (≥1).

Ports:
- `clk`, input, 1: system clock.
- `resetn`, input, 1: asynchronous, active-low block reset (power-on).
- `src_req_n`, input, N_SRC: asynchronous active-low reset requests (keys, EJTAG reset).
- `src_mask`, input, N_SRC: 1 = source enabled. Quasi-static; sampled directly.
- `pll_locked`, input, 1: asynchronous PLL lock; low = reset request.
- `sw_reset_req`, input, 1: synchronous single-cycle software reset pulse.
- `cause_clr`, input, 1: synchronous; clears `last_cause`.
- `rst_n_out`, output, N_DOMAINS: registered active-low domain resets. Bit 0 is released first.
- `reset_active`, output, 1: registered; high whenever any `rst_n_out` bit is low.
- `last_cause`, output, N_SRC+2: sticky cause bits.
  - Bits [N_SRC-1:0] are the external sources.
  - Bit N_SRC is PLL lock loss.
  - Bit N_SRC+1 is the software request.

## Operation

- **Synchronisers:**
  - `src_req_n` flops reset to 1 (inactive).
  - `pll_locked` flops reset to 0 (unlocked).
- **Per-source debounce:**
  - The counter clears whenever the synchronised level equals the current debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level toggles and the counter clears.
  - Debounced request resets to inactive.
- **Request combination:** `req_any` = OR of (debounced request AND `src_mask`), NOT synchronised `pll_locked`, and `sw_reset_req`. PLL lock is not debounced.
- **State machine** (reset state ASSERT, counter 0):
  - **ASSERT:**
    - All `rst_n_out` = 0.
    - The counter clears on any cycle with `req_any` high, else increments.
    - When the counter = MIN_ASSERT-1 and `req_any` is low: go to RELEASE, set `rst_n_out[0]` = 1, clear the counter.
  - **RELEASE:**
    - The counter increments.
    - At STAGE_DELAY-1 the next domain bit is set, the stage index advances and the counter clears.
    - Setting bit N_DOMAINS-1 enters RUN.
    - `req_any` high: go to ASSERT; all outputs 0 and counter 0 on the same edge.
  - **RUN:** all outputs 1. `req_any` high: go to ASSERT; all outputs 0 on that edge.
  - N_DOMAINS = 1: leaving ASSERT enters RUN directly.
- **Cause capture:**
  - On a RUN/RELEASE→ASSERT edge, each cause bit whose request term is high is OR-ed into `last_cause`.
  - Requests while already in ASSERT are not recorded.
  - `cause_clr` zeroes the register. A set on the same edge wins over the clear for that bit.
- **`resetn` low:** asynchronously forces ASSERT, all outputs 0, `reset_active` = 1, counters 0, `last_cause` = 0. This applies mid-sequence too.

## Timing

- **Reset values:**
  - `rst_n_out` = 0, `reset_active` = 1, `last_cause` = 0.
  - Internal state: ASSERT.
- **Request to reset:** `rst_n_out` goes to 0 on the first edge at which `req_any` is sampled high, i.e. one cycle after it.
  - `sw_reset_req`: 1 cycle.
  - `pll_locked` fall: SYNC_STAGES+1 edges.
  - External source: SYNC_STAGES+DEBOUNCE_CYCLES+1 edges.
- **Glitch rejection:** a source pulse shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- **Release timing:**
  - If the last edge sampling `req_any` high is edge t, `rst_n_out[0]` rises at edge t+MIN_ASSERT.
  - `rst_n_out[k]` rises at t+MIN_ASSERT+k·STAGE_DELAY.
  - `reset_active` falls with the last stage.
- **Power-up:** with `pll_locked` = 1 and all sources idle, `rst_n_out[0]` rises at edge SYNC_STAGES+MIN_ASSERT after `resetn` rises.
- **Counter width:** clog2 of the largest of MIN_ASSERT, STAGE_DELAY and DEBOUNCE_CYCLES, +1. Counters never wrap.

## Test plan

All scenarios use the default parameters with `src_mask` = 2'b11 unless stated.

1. **Power-up.** Stimulus: `resetn` 0→1, `pll_locked` = 1, sources high. Required response:
   - `rst_n_out[0]` rises at edge 18, `[1]` at edge 26, `[2]` at edge 34.
   - `reset_active` falls at edge 34; `last_cause` = 4'b0000.
2. **Debounce.** Stimulus in RUN: `src_req_n[0]` low for 3 cycles, then later low for 10 cycles. Required response:
   - The 3-cycle pulse causes no output change.
   - The 10-cycle pulse drives all outputs 0 at 7 edges after its fall; `last_cause` = 4'b0001.
   - Release follows at the last request + 16/24/32 edges.
3. **Masked source.** Stimulus: `src_mask` = 2'b01, `src_req_n[1]` held low 50 cycles. Required response: outputs stay 3'b111; `last_cause` unchanged.
4. **Software reset.** Stimulus: one-cycle `sw_reset_req` in RUN. Required response:
   - Outputs 0 on the next edge.
   - `rst_n_out[0]` rises 16 edges after the pulse edge.
   - `last_cause[3]` = 1.
5. **Interrupted release.** Stimulus: `sw_reset_req` 3 cycles after `rst_n_out[0]` rises. Required response:
   - All outputs 0 on the next edge.
   - Full 16/8/8 sequence restarts.
   - `last_cause[3]` set.
6. **PLL loss and cause clear.** Stimulus: 1-cycle `pll_locked` drop in RUN with `cause_clr` pulsed on the capture edge. Required response:
   - Outputs 0 at 3 edges after the drop.
   - `last_cause` = 4'b0100 (set wins).
   - A later `cause_clr` gives 4'b0000.
   - `resetn` pulsed low mid-RELEASE gives immediate all-0 outputs and `last_cause` = 0.
